// File: rtl/wb_write_queue_if.sv
// Producer-side result handshake for wb_write_queue.
//   in_valid  producer offers a result this cycle
//   in_ready  queue can accept; transfer at posedge when in_valid && in_ready
//   in_rd     destination register index
//   in_data   result value
// master = writeback stage (producer), slave = write queue.
interface wb_write_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;

  modport master (output in_valid, output in_rd, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rd, input in_data, output in_ready);
endinterface

// File: rtl/wb_write_queue.sv
// In-order write queue owning the register-file write port. Accepts writeback
// results, buffers them in a DEPTH-entry circular FIFO and retires at most one
// per cycle onto RegWrite/rd/write_data. A forwarding lookup exposes values
// still queued so decode can bypass them.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   in_port (slave)       in_valid/in_ready/in_rd/in_data result handshake
//   drain_en              permits retiring the head entry this cycle
//   RegWrite, rd,         register file write port (head entry)
//   write_data
//   count                 occupied entries
//   fwd_rs1/2             decode-stage source indices to look up
//   fwd_hit1/2,           youngest queued match for each source (0 on miss)
//   fwd_data1/2
//
// Configuration macro: WBQ_FORWARD_EN builds the forwarding search; when
// undefined the forwarding outputs are tied to zero.
module wb_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  wb_write_queue_if.slave   in_port,
  input  logic              drain_en,
  output logic              RegWrite,
  output logic [4:0]        rd,
  output logic [31:0]       write_data,
  output logic [PTR_W:0]    count,
  input  logic [4:0]        fwd_rs1,
  input  logic [4:0]        fwd_rs2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [31:0]       fwd_data1,
  output logic [31:0]       fwd_data2
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [4:0]       mem_rd   [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic             not_empty;
  logic             accept;
  logic             push;
  logic             pop;

  // Status and retire strobe depend only on registered state (+ drain_en).
  assign not_empty        = (count_q != '0);
  assign in_port.in_ready = (count_q < DEPTH_C);
  assign RegWrite         = drain_en && not_empty && !reset;
  assign rd               = not_empty ? mem_rd[rd_ptr_q]   : 5'd0;
  assign write_data       = not_empty ? mem_data[rd_ptr_q] : 32'd0;
  assign count            = count_q;

  // Writes to x0 complete the handshake but are dropped without storage.
  assign accept = in_port.in_valid && in_port.in_ready;
  assign push   = accept && (in_port.in_rd != 5'd0);
  assign pop    = RegWrite;

  // Pointer and occupancy tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + (PTR_W+1)'(1);
      else if (pop && !push) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  // Entry storage; unoccupied slots are never observed, so no reset needed.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_rd[wr_ptr_q]   <= in_port.in_rd;
      mem_data[wr_ptr_q] <= in_port.in_data;
    end
  end

`ifdef WBQ_FORWARD_EN
  // Walk occupied entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = 32'd0;
    fwd_data2 = 32'd0;
    idx       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((PTR_W+1)'(i) < count_q) begin
        if (fwd_rs1 != 5'd0 && mem_rd[idx] == fwd_rs1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem_data[idx];
        end
        if (fwd_rs2 != 5'd0 && mem_rd[idx] == fwd_rs2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem_data[idx];
        end
      end
    end
  end
`else
  // Forwarding disabled: outputs tied off, lookup indices intentionally ignored.
  logic unused_fwd_rs;
  assign unused_fwd_rs = ^{fwd_rs1, fwd_rs2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = 32'd0;
  assign fwd_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (DEPTH=4).
module tb_wb_write_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic              drain_en;
  logic              RegWrite;
  logic [4:0]        rd;
  logic [31:0]       write_data;
  logic [PTR_W:0]    count;
  logic [4:0]        fwd_rs1, fwd_rs2;
  logic              fwd_hit1, fwd_hit2;
  logic [31:0]       fwd_data1, fwd_data2;

  int checks   = 0;
  int failures = 0;

  wb_write_queue_if bus ();

  wb_write_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_port    (bus),
    .drain_en   (drain_en),
    .RegWrite   (RegWrite),
    .rd         (rd),
    .write_data (write_data),
    .count      (count),
    .fwd_rs1    (fwd_rs1),
    .fwd_rs2    (fwd_rs2),
    .fwd_hit1   (fwd_hit1),
    .fwd_hit2   (fwd_hit2),
    .fwd_data1  (fwd_data1),
    .fwd_data2  (fwd_data2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs settle after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_rd    = r;
    bus.in_data  = d;
  endtask

  logic        exp_hit1;
  logic [31:0] exp_data1;

  initial begin
    reset    = 1'b1;
    drain_en = 1'b0;
    fwd_rs1  = 5'd5;
    fwd_rs2  = 5'd0;
    offer(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset values
    chk("rst_count",    32'(count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_rd",       32'(rd), 32'd0);
    chk("rst_wdata",    write_data, 32'd0);
    chk("rst_hit1",     32'(fwd_hit1), 32'd0);
    chk("rst_hit2",     32'(fwd_hit2), 32'd0);
    chk("rst_fdata1",   fwd_data1, 32'd0);
    chk("rst_fdata2",   fwd_data2, 32'd0);

    // Single push, commit one cycle later
    drain_en = 1'b1;
    offer(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    chk("single_no_same_cycle_write", 32'(RegWrite), 32'd0);
    tick();
    offer(1'b0, 5'd0, 32'd0);
    #1;
    chk("single_regwrite", 32'(RegWrite), 32'd1);
    chk("single_rd",       32'(rd), 32'd5);
    chk("single_wdata",    write_data, 32'hDEADBEEF);
    chk("single_count1",   32'(count), 32'd1);
    tick();
    chk("single_count0",   32'(count), 32'd0);
    chk("single_idle",     32'(RegWrite), 32'd0);

    // Fill to full with drain held off, 5th push held
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer(1'b1, 5'(11 + i), 32'h100 + 32'(i));
      #1;
      chk($sformatf("fill_ready%0d", i), 32'(bus.in_ready), 32'd1);
      tick();
    end
    offer(1'b1, 5'd15, 32'h104);
    #1;
    chk("full_count",    32'(count), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_no_write", 32'(RegWrite), 32'd0);
    tick();
    chk("full_held_count", 32'(count), 32'd4);

    // Drain: commits in order on consecutive cycles, 5th enters after first pop
    drain_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("drain_we%0d", k), 32'(RegWrite), 32'd1);
      chk($sformatf("drain_rd%0d", k), 32'(rd), 32'(11 + k));
      chk($sformatf("drain_wd%0d", k), write_data, 32'h100 + 32'(k));
      if (k == 1) begin
        chk("drain_count_after_pop", 32'(count), 32'd3);
        chk("drain_ready_after_pop", 32'(bus.in_ready), 32'd1);
      end
      tick();
      if (k == 1) offer(1'b0, 5'd0, 32'd0);
    end
    chk("drain_empty", 32'(count), 32'd0);

    // Push to x0: handshake completes, nothing stored or written
    offer(1'b1, 5'd0, 32'h1234);
    #1;
    chk("x0_ready", 32'(bus.in_ready), 32'd1);
    tick();
    offer(1'b0, 5'd0, 32'd0);
    #1;
    chk("x0_count", 32'(count), 32'd0);
    chk("x0_no_write", 32'(RegWrite), 32'd0);
    tick();
    chk("x0_no_write2", 32'(RegWrite), 32'd0);

    // Forwarding: youngest duplicate wins, miss reads zero
    drain_en = 1'b0;
    offer(1'b1, 5'd7, 32'h11);
    tick();
    offer(1'b1, 5'd7, 32'h22);
    tick();
    // Current-cycle input targeting rs2 must not be searched
    offer(1'b1, 5'd3, 32'h99);
    fwd_rs1 = 5'd7;
    fwd_rs2 = 5'd3;
    #1;
`ifdef WBQ_FORWARD_EN
    exp_hit1  = 1'b1;
    exp_data1 = 32'h22;
`else
    exp_hit1  = 1'b0;
    exp_data1 = 32'h0;
`endif
    chk("fwd_hit1",   32'(fwd_hit1), 32'(exp_hit1));
    chk("fwd_data1",  fwd_data1, exp_data1);
    chk("fwd_hit2",   32'(fwd_hit2), 32'd0);
    chk("fwd_data2",  fwd_data2, 32'd0);
    offer(1'b0, 5'd0, 32'd0);
    drain_en = 1'b1;
    #1;
    chk("fwd_hit1_while_retiring",  32'(fwd_hit1), 32'(exp_hit1));
    chk("fwd_data1_while_retiring", fwd_data1, exp_data1);
    chk("fwd_head_rd", 32'(rd), 32'd7);
    chk("fwd_head_wd", write_data, 32'h11);
    tick();
    chk("fwd_second_wd", write_data, 32'h22);
    tick();
    chk("fwd_drained_count", 32'(count), 32'd0);
    chk("fwd_drained_hit1",  32'(fwd_hit1), 32'd0);

    // Continuous push + pop for 10 cycles, pointers wrap
    offer(1'b1, 5'd1, 32'hA1);
    tick();
    for (int j = 2; j <= 10; j++) begin
      offer(1'b1, 5'(j), 32'hA0 + 32'(j));
      #1;
      chk($sformatf("stream_count%0d", j), 32'(count), 32'd1);
      chk($sformatf("stream_we%0d", j),    32'(RegWrite), 32'd1);
      chk($sformatf("stream_rd%0d", j),    32'(rd), 32'(j - 1));
      chk($sformatf("stream_wd%0d", j),    write_data, 32'hA0 + 32'(j - 1));
      tick();
    end
    offer(1'b0, 5'd0, 32'd0);
    #1;
    chk("stream_last_rd", 32'(rd), 32'd10);
    chk("stream_last_wd", write_data, 32'hAA);
    tick();
    chk("stream_empty", 32'(count), 32'd0);

    // Reset with three pending entries discards them
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, 5'(20 + i), 32'h200 + 32'(i));
      tick();
    end
    offer(1'b0, 5'd0, 32'd0);
    #1;
    chk("prerst_count", 32'(count), 32'd3);
    drain_en = 1'b1;
    reset    = 1'b1;
    #1;
    chk("rst_cycle_no_write", 32'(RegWrite), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("postrst_count",    32'(count), 32'd0);
    chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("postrst_no_write", 32'(RegWrite), 32'd0);
    tick();
    chk("postrst_no_write2", 32'(RegWrite), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
